// File: rtl/time_display_scanner_pkg.sv
// Shared definitions for the HH.MM display scanner.
// Contents: active-low segment codes, active-low anode selects, digit
// slot indices, conversion FSM states and a slot-to-anode helper.
package time_display_scanner_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low anode selects, one digit low at a time
    localparam logic [3:0] AN_MU  = 4'b1110;
    localparam logic [3:0] AN_MT  = 4'b1101;
    localparam logic [3:0] AN_HU  = 4'b1011;
    localparam logic [3:0] AN_HT  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Scan slot indices
    localparam logic [1:0] IDX_MU = 2'd0;
    localparam logic [1:0] IDX_MT = 2'd1;
    localparam logic [1:0] IDX_HU = 2'd2;
    localparam logic [1:0] IDX_HT = 2'd3;

    // Binary-to-BCD conversion FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DIV_H  = 3'd2,
        ST_DIV_M  = 3'd3,
        ST_COMMIT = 3'd4
    } conv_state_t;

    // Anode pattern that enables the given scan slot
    function automatic logic [3:0] anode_for_idx(input logic [1:0] idx);
        logic [3:0] an_v;
        case (idx)
            IDX_MU:  an_v = AN_MU;
            IDX_MT:  an_v = AN_MT;
            IDX_HU:  an_v = AN_HU;
            IDX_HT:  an_v = AN_HT;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage

// File: rtl/time_display_scanner_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment code.
// Ports:
//   digit  in  4  BCD digit; codes 10..15 decode to all segments off
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decoder
    import time_display_scanner_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit to segment lookup; unused codes blank the digit
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display_scanner.sv
// Time display scanner: converts binary hours/minutes to BCD with a
// sequential subtract-by-ten converter and multiplexes the four digits of
// a common-anode display as HH.MM. The field under adjustment blinks and
// the colon follows seconds[0] (held on while adjusting).
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   hours    in   5  binary hours
//   minutes  in   6  binary minutes
//   seconds  in   6  binary seconds, only bit 0 used
//   adj_en   in   1  adjust mode active
//   adj_hr   in   1  adjust field select: 1 = hours, 0 = minutes
//   seg      out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an       out  4  digit anodes, active-low, an[0] = minutes units
//   dp       out  1  colon / decimal point, active-low
module time_display_scanner
    import time_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adj_en,
    input  logic       adj_hr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    // Timing chain
    logic [PRE_W-1:0] pre_cnt_r;
    logic [BLK_W-1:0] blk_cnt_r;
    logic             tick_s;
    logic             phase_off_r;
    logic [1:0]       idx_r;

    // Conversion datapath
    conv_state_t      state_r;
    conv_state_t      state_nxt_s;
    logic [10:0]      snap_r;
    logic [4:0]       hrs_w_r;
    logic [5:0]       min_w_r;
    logic [1:0]       ht_w_r;
    logic [2:0]       mt_w_r;
    logic [3:0]       ht_r;
    logic [3:0]       hu_r;
    logic [3:0]       mt_r;
    logic [3:0]       mu_r;

    // Scan selection and output registers
    logic [3:0]       scan_digit_s;
    logic [3:0]       scan_an_s;
    logic [6:0]       scan_seg_s;
    logic             blank_s;
    logic             colon_s;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;
    logic             dp_r;

    // Only the seconds LSB drives the colon
    logic             unused_seconds_s;
    assign unused_seconds_s = ^seconds[5:1];

    assign tick_s = (pre_cnt_r == PRE_LAST);

    // Refresh prescaler: wraps after REFRESH_DIV cycles, tick on the last count
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

    // Digit slot index advances once per tick, 0..3 and back
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= IDX_MU;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Blink phase toggles every BLINK_TICKS ticks; phase_off_r=1 is the dark half
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_r   <= '0;
            phase_off_r <= 1'b0;
        end else if (tick_s) begin
            if (blk_cnt_r == BLK_LAST) begin
                blk_cnt_r   <= '0;
                phase_off_r <= ~phase_off_r;
            end else begin
                blk_cnt_r   <= blk_cnt_r + BLK_ONE;
                phase_off_r <= phase_off_r;
            end
        end else begin
            blk_cnt_r   <= blk_cnt_r;
            phase_off_r <= phase_off_r;
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion FSM next-state logic; inputs are only sampled in IDLE/LOAD,
    // so a change mid-conversion is picked up by the snapshot compare later
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ({hours, minutes} != snap_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_DIV_H;
            end
            ST_DIV_H: begin
                if (hrs_w_r < 5'd10) begin
                    state_nxt_s = ST_DIV_M;
                end else begin
                    state_nxt_s = ST_DIV_H;
                end
            end
            ST_DIV_M: begin
                if (min_w_r < 6'd10) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_DIV_M;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath: repeated subtract-by-ten, then a single-cycle
    // commit of all four digits so the display never shows a mixed value
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r  <= 11'd0;
            hrs_w_r <= 5'd0;
            min_w_r <= 6'd0;
            ht_w_r  <= 2'd0;
            mt_w_r  <= 3'd0;
            ht_r    <= 4'd0;
            hu_r    <= 4'd0;
            mt_r    <= 4'd0;
            mu_r    <= 4'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    snap_r  <= {hours, minutes};
                    hrs_w_r <= hours;
                    min_w_r <= minutes;
                    ht_w_r  <= 2'd0;
                    mt_w_r  <= 3'd0;
                end
                ST_DIV_H: begin
                    if (hrs_w_r >= 5'd10) begin
                        hrs_w_r <= hrs_w_r - 5'd10;
                        ht_w_r  <= ht_w_r + 2'd1;
                    end
                end
                ST_DIV_M: begin
                    if (min_w_r >= 6'd10) begin
                        min_w_r <= min_w_r - 6'd10;
                        mt_w_r  <= mt_w_r + 3'd1;
                    end
                end
                ST_COMMIT: begin
                    ht_r <= {2'b00, ht_w_r};
                    hu_r <= hrs_w_r[3:0];
                    mt_r <= {1'b0, mt_w_r};
                    mu_r <= min_w_r[3:0];
                end
                default: begin
                    snap_r <= snap_r;
                end
            endcase
        end
    end

    // Select the digit, anode, blanking and colon for the current slot
    always_comb begin
        scan_digit_s = mu_r;
        scan_an_s    = anode_for_idx(idx_r);
        blank_s      = 1'b0;
        colon_s      = 1'b0;
        case (idx_r)
            IDX_MU: begin
                scan_digit_s = mu_r;
                blank_s      = adj_en & phase_off_r & ~adj_hr;
            end
            IDX_MT: begin
                scan_digit_s = mt_r;
                blank_s      = adj_en & phase_off_r & ~adj_hr;
            end
            IDX_HU: begin
                scan_digit_s = hu_r;
                blank_s      = adj_en & phase_off_r & adj_hr;
                colon_s      = adj_en | ~seconds[0];
            end
            IDX_HT: begin
                scan_digit_s = ht_r;
                blank_s      = adj_en & phase_off_r & adj_hr;
            end
            default: begin
                scan_digit_s = 4'hF;
                blank_s      = 1'b1;
            end
        endcase
    end

    seg7_decoder u_seg7 (
        .digit (scan_digit_s),
        .seg   (scan_seg_s)
    );

    // Output registers: an and seg update together so no ghosting
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= AN_OFF;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= scan_seg_s;
            an_r  <= blank_s ? AN_OFF : scan_an_s;
            dp_r  <= ~colon_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner (REFRESH_DIV=4, BLINK_TICKS=8).
// The reference derives scan slot and blink phase from elapsed cycles since
// reset, and digits from decimal arithmetic on the applied time. While a
// conversion may be in flight, each shown digit must belong to one of the
// values applied since the display last settled.
module tb_time_display_scanner;

    localparam int RD     = 4;
    localparam int BT     = 8;
    localparam int SETTLE = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hours = 5'd0;
    logic [5:0] minutes = 6'd0;
    logic [5:0] seconds = 6'd0;
    logic       adj_en = 1'b0;
    logic       adj_hr = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_chk  = 0;
    int n_pass = 0;
    int k_cyc  = 0;
    int settle = 0;
    int cand_q[$];

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    time_display_scanner #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
        .clk     (clk),
        .rst     (rst),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .adj_en  (adj_en),
        .adj_hr  (adj_hr),
        .seg     (seg),
        .an      (an),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was released
    always @(posedge clk) begin
        if (rst) k_cyc <= 0;
        else     k_cyc <= k_cyc + 1;
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", tag, obs, exp, k_cyc, $time);
    endtask

    function automatic int cur_val();
        return int'(hours) * 100 + int'(minutes);
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int h;
        int m;
        h = v / 100;
        m = v % 100;
        case (idx)
            0:       return m % 10;
            1:       return m / 10;
            2:       return h % 10;
            default: return h / 10;
        endcase
    endfunction

    // Advance one cycle and compare every output against the reference
    task automatic step();
        int  idx;
        int  ph;
        bit  ok;
        logic [3:0] exp_an;
        logic       exp_dp;
        @(negedge clk);
        settle++;
        if (settle >= SETTLE) begin
            cand_q.delete();
            cand_q.push_back(cur_val());
        end
        if (k_cyc == 0) begin
            check_val("seg_reset", 16'(seg), 16'h007F);
            check_val("an_reset", 16'(an), 16'h000F);
            check_val("dp_reset", 16'(dp), 16'h0001);
        end else begin
            idx = ((k_cyc - 1) / RD) % 4;
            ph  = (((k_cyc - 1) / RD) / BT) % 2;
            exp_an = ~(4'b0001 << idx);
            if (adj_en && ph == 1 && ((adj_hr && idx >= 2) || (!adj_hr && idx < 2)))
                exp_an = 4'hF;
            exp_dp = !(idx == 2 && (adj_en || !seconds[0]));
            check_val("an", 16'(an), 16'(exp_an));
            check_val("dp", 16'(dp), 16'(exp_dp));
            if (cand_q.size() == 1) begin
                check_val("seg", 16'(seg), 16'(seg_tab[digit_of(cand_q[0], idx)]));
            end else begin
                ok = 1'b0;
                foreach (cand_q[i]) if (seg == seg_tab[digit_of(cand_q[i], idx)]) ok = 1'b1;
                check_val("seg_transient", 16'(ok), 16'h0001);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input int h, input int m);
        hours   = 5'(h);
        minutes = 6'(m);
        settle  = 0;
        cand_q.push_back(cur_val());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
        settle = 0;
        cand_q.delete();
        cand_q.push_back(0);
        cand_q.push_back(cur_val());
    endtask

    initial begin
        // Reset with 00:00, then all digits show 0 and anodes rotate
        do_reset(3);
        run(40);

        // Full-range value
        set_time(23, 59);
        run(40);

        // Out-of-range values are shown arithmetically
        set_time(31, 63);
        run(40);

        // Minutes change on the cycle after LOAD: 30 -> 09 -> 10
        set_time(12, 30);
        run(40);
        set_time(12, 9);
        run(2);
        set_time(12, 10);
        run(40);

        // Hours field blinks, then minutes field
        adj_en = 1'b1;
        adj_hr = 1'b1;
        run(130);
        adj_hr = 1'b0;
        run(130);

        // Colon behaviour
        adj_en = 1'b0;
        seconds = 6'd0;
        run(20);
        seconds = 6'd1;
        run(20);
        adj_en = 1'b1;
        run(20);
        adj_en = 1'b0;

        // Reset while the converter is in DIV_M
        set_time(5, 7);
        run(40);
        set_time(23, 59);
        run(6);
        do_reset(1);
        run(40);

        // Randomized segments
        for (int s = 0; s < 25; s++) begin
            int h;
            int m;
            int hold;
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
            m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59);
            adj_en = ($urandom_range(0, 2) == 0);
            adj_hr = 1'($urandom_range(0, 1));
            set_time(h, m);
            hold = $urandom_range(40, 60);
            for (int c = 0; c < hold; c++) begin
                step();
                if ($urandom_range(0, 7) == 0) seconds = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
